regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have port `clock`: input, 1 bit, the single rising-edge clock.
REQ-002 SHALL have port `reset_n`: input, 1 bit; asynchronous, active-low reset.
REQ-003 SHALL have inputs `w_stall` and `w_bubble`, 1 bit each; these are the W-register pipeline controls.
REQ-004 SHALL have the following M-stage inputs:
- `m_stat` 3 bits: AOK=1, HLT=2, ADR=3, INS=4.
- `m_icode` 4 bits.
- `m_valE` 64 bits and `m_valM` 64 bits.
- `m_dstE` 4 bits and `m_dstM` 4 bits; 4'hF means no destination.
REQ-005 SHALL have inputs `srcA` and `srcB`, 4 bits each; these are the read register IDs from decode, with 4'hF meaning none.
REQ-006 SHALL have outputs `valA` and `valB`, 64 bits each; these are the read data.
REQ-007 SHALL have the following W-register outputs, used for forwarding: `w_stat` 3 bits, `w_icode` 4 bits, `w_valE` 64 bits, `w_valM` 64 bits, `w_dstE` 4 bits, `w_dstM` 4 bits.
REQ-008 SHALL have output `halted`, 1 bit, which is sticky.

Function
REQ-009 SHALL hold 15 registers of 64 bits each, with IDs 0–14; ID 15 is not storage.
REQ-010 SHALL update the W register on each rising `clock` edge as follows:
- If `halted` or `w_stall` is asserted: hold its contents.
- Else if `w_bubble` is asserted: load a bubble (stat=AOK, icode=1 (nop), dstE=dstM=4'hF, valE=valM=0).
- Otherwise: load the `m_*` inputs.
REQ-011 SHALL write to registers on a rising edge only from the current W contents, and only when `w_stat`==AOK and `halted`==0.
- Write `w_valE` to `w_dstE` if it is not 4'hF.
- Write `w_valM` to `w_dstM` if it is not 4'hF.
REQ-012 SHALL, when `w_dstE`==`w_dstM` (not 4'hF), let the M write win (popq %rsp semantics).
REQ-013 SHALL drive reads combinationally with zero latency: `valA` = reg[`srcA`] and `valB` = reg[`srcB`]; a read of ID 4'hF SHALL return 64'h0.
REQ-014 SHALL set `halted` on the rising edge at which `w_stat`≠AOK; once set, it SHALL remain set until reset.
REQ-015 SHALL, when the write that would coincide with the `halted` set is for the excepting instruction (`w_stat`≠AOK), suppress that write.
REQ-016 SHALL treat `w_stall` and `w_bubble` asserted together as stall; stall wins.
REQ-017 SHALL ignore `m_icode`, except that it is latched into the W register.

Reset
REQ-018 SHALL, while `reset_n`=0 (asynchronously, including mid-operation), set:
- all 15 registers to 0;
- the W register to the bubble of REQ-010;
- `halted` to 0.
REQ-019 SHALL, after reset, produce output values as follows:
- `valA`, `valB`: 0.
- `w_stat`: 1.
- `w_icode`: 1.
- `w_dstE`, `w_dstM`: 4'hF.
- `w_valE`, `w_valM`: 0.
- `halted`: 0.
REQ-020 SHALL perform its first write no earlier than the second rising edge after `reset_n` deasserts.

Configuration
REQ-021 SHALL provide the macro `REGFILE_BYPASS_EN`, which controls same-cycle write-to-read bypass:
- Defined: if a read ID equals an enabled pending write destination in the current W register, `valA`/`valB` SHALL return the pending value. `w_dstM` takes priority over `w_dstE`.
- Undefined: reads SHALL return the pre-edge stored value, with no bypass; upstream forwarding covers the hazard.

Structure
REQ-022 SHALL place the following in the shared package `y86_pkg`:
- Stat codes STAT_AOK, STAT_HLT, STAT_ADR and STAT_INS.
- Icode constants, including I_NOP=4'h1.
- REG_NONE=4'hF and REG_RSP=4'h4.
- WORD_W=64.
REQ-023 SHALL implement the W register as the sub-module `w_pipe_reg`, which handles stall, bubble and the reset of REQ-018; the register array and read/write logic SHALL remain in `regfile_writeback`.

Verification
REQ-024 Write then read:
- Stimulus: m_stat=1, m_dstE=3, m_valE=64'h2A.
- Response: two edges later, with srcA=3, valA=64'h2A.
REQ-025 Dual-write conflict:
- Stimulus: m_dstE=m_dstM=4, m_valE=64'h100, m_valM=64'h55.
- Response: after writeback, reg4=64'h55.
REQ-026 Stall and bubble:
- Stimulus: w_stall=1 with new m_dstE=5.
- Response: W holds and reg5 is unchanged.
- Stimulus: w_bubble=1.
- Response: w_dstE=4'hF and no write occurs.
REQ-027 Halt:
- Stimulus: m_stat=2 reaches W.
- Response: halted=1 on that edge; subsequent writes with m_stat=1, dstE=2 leave reg2 unchanged.
REQ-028 Bypass:
- Stimulus: W holds dstE=6, valE=64'h77, with srcB=6 in the same cycle.
- Response: valB=64'h77 with REGFILE_BYPASS_EN defined; valB=old reg6 without it.
REQ-029 Asynchronous reset:
- Stimulus: reset_n pulsed low mid-run with no clock edge.
- Response: all registers read 0, w_stat=1, halted=0, and srcA=4'hF gives valA=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: stat codes, icodes, register IDs and the W-stage record.
package y86_pkg;

   localparam int WORD_W = 64;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] REG_NONE = 4'hF;

   typedef struct packed {
      logic [2:0]        stat;
      logic [3:0]        icode;
      logic [WORD_W-1:0] valE;
      logic [WORD_W-1:0] valM;
      logic [3:0]        dstE;
      logic [3:0]        dstM;
   } w_reg_t;

   function automatic w_reg_t w_bubble_val();
      w_reg_t b;
      b.stat  = STAT_AOK;
      b.icode = I_NOP;
      b.valE  = '0;
      b.valM  = '0;
      b.dstE  = REG_NONE;
      b.dstM  = REG_NONE;
      return b;
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bus between the M/W pipeline side and the writeback register file.
interface regfile_writeback_if;
   import y86_pkg::*;

   logic              w_stall;
   logic              w_bubble;
   logic [2:0]        m_stat;
   logic [3:0]        m_icode;
   logic [WORD_W-1:0] m_valE;
   logic [WORD_W-1:0] m_valM;
   logic [3:0]        m_dstE;
   logic [3:0]        m_dstM;
   logic [3:0]        srcA;
   logic [3:0]        srcB;
   logic [WORD_W-1:0] valA;
   logic [WORD_W-1:0] valB;
   logic [2:0]        w_stat;
   logic [3:0]        w_icode;
   logic [WORD_W-1:0] w_valE;
   logic [WORD_W-1:0] w_valM;
   logic [3:0]        w_dstE;
   logic [3:0]        w_dstM;
   logic              halted;

   modport master (
      output w_stall, w_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, srcA, srcB,
      input  valA, valB, w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM, halted
   );

   modport slave (
      input  w_stall, w_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, srcA, srcB,
      output valA, valB, w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM, halted
   );
endinterface

// File: rtl/regfile_writeback_w_pipe_reg.sv
// W pipeline register: hold beats bubble, bubble beats load; resets to a nop bubble.
module w_pipe_reg
   import y86_pkg::*;
(
   input  logic   clock,
   input  logic   reset_n,
   input  logic   hold,
   input  logic   bubble,
   input  w_reg_t m_in,
   output w_reg_t w_q
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         w_q <= w_bubble_val();
      end else if (hold) begin
         w_q <= w_q;
      end else if (bubble) begin
         w_q <= w_bubble_val();
      end else begin
         w_q <= m_in;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: W register, 15x64 register file, sticky halt.
// Optional macro REGFILE_BYPASS_EN forwards the pending W write to the read ports.
module regfile_writeback
   import y86_pkg::*;
(
   input logic               clock,
   input logic               reset_n,
   regfile_writeback_if.slave rf
);

   w_reg_t            m_in;
   w_reg_t            w_q;
   logic              halted_q;
   logic              write_en;
   logic [WORD_W-1:0] regs [15];

   assign m_in.stat  = rf.m_stat;
   assign m_in.icode = rf.m_icode;
   assign m_in.valE  = rf.m_valE;
   assign m_in.valM  = rf.m_valM;
   assign m_in.dstE  = rf.m_dstE;
   assign m_in.dstM  = rf.m_dstM;

   w_pipe_reg u_w_pipe_reg (
      .clock   (clock),
      .reset_n (reset_n),
      .hold    (halted_q | rf.w_stall),
      .bubble  (rf.w_bubble),
      .m_in    (m_in),
      .w_q     (w_q)
   );

   // An excepting instruction never commits, so its stat gates its own write.
   assign write_en = (w_q.stat == STAT_AOK) && !halted_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 15; i++) regs[i] <= '0;
         halted_q <= 1'b0;
      end else begin
         if (write_en && (w_q.dstE != REG_NONE)) regs[w_q.dstE] <= w_q.valE;
         // Later assignment wins: popq %rsp keeps the loaded value.
         if (write_en && (w_q.dstM != REG_NONE)) regs[w_q.dstM] <= w_q.valM;
         if (w_q.stat != STAT_AOK) halted_q <= 1'b1;
      end
   end

   function automatic logic [WORD_W-1:0] read_port(input logic [3:0] id);
      logic [WORD_W-1:0] v;
      v = '0;
      if (id != REG_NONE) begin
         v = regs[id];
`ifdef REGFILE_BYPASS_EN
         if (write_en && (w_q.dstM == id)) v = w_q.valM;
         else if (write_en && (w_q.dstE == id)) v = w_q.valE;
`endif
      end
      return v;
   endfunction

   assign rf.valA    = read_port(rf.srcA);
   assign rf.valB    = read_port(rf.srcB);
   assign rf.w_stat  = w_q.stat;
   assign rf.w_icode = w_q.icode;
   assign rf.w_valE  = w_q.valE;
   assign rf.w_valM  = w_q.valM;
   assign rf.w_dstE  = w_q.dstE;
   assign rf.w_dstM  = w_q.dstM;
   assign rf.halted  = halted_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback with an in-bench reference model.
`timescale 1ns/10ps
module tb_regfile_writeback;

   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   regfile_writeback_if rf();

   regfile_writeback dut (
      .clock   (clock),
      .reset_n (reset_n),
      .rf      (rf)
   );

   always #5 clock = ~clock;

   // Reference state: architectural registers, the W latch and the halt flag.
   logic [63:0] mregs [15];
   logic [2:0]  ms;
   logic [3:0]  mi, mde, mdm;
   logic [63:0] mve, mvm;
   bit          mhalt;

   function automatic bit model_we();
      return (ms == 3'd1) && !mhalt;
   endfunction

   function automatic logic [63:0] model_read(input logic [3:0] id);
      if (id == 4'hF) return 64'h0;
`ifdef REGFILE_BYPASS_EN
      if (model_we() && mdm == id) return mvm;
      if (model_we() && mde == id) return mve;
`endif
      return mregs[id];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) mregs[i] = 64'h0;
      ms = 3'd1; mi = 4'h1; mve = 64'h0; mvm = 64'h0; mde = 4'hF; mdm = 4'hF;
      mhalt = 1'b0;
   endtask

   task automatic model_step();
      bit was_halted;
      was_halted = mhalt;
      if (model_we()) begin
         if (mde != 4'hF) mregs[mde] = mve;
         if (mdm != 4'hF) mregs[mdm] = mvm;
      end
      if (ms != 3'd1) mhalt = 1'b1;
      if (was_halted || rf.w_stall) begin
         // W unchanged
      end else if (rf.w_bubble) begin
         ms = 3'd1; mi = 4'h1; mve = 64'h0; mvm = 64'h0; mde = 4'hF; mdm = 4'hF;
      end else begin
         ms = rf.m_stat; mi = rf.m_icode; mve = rf.m_valE; mvm = rf.m_valM;
         mde = rf.m_dstE; mdm = rf.m_dstM;
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         check("valA", rf.valA, model_read(rf.srcA));
         check("valB", rf.valB, model_read(rf.srcB));
         check("w_stat", {61'h0, rf.w_stat}, {61'h0, ms});
         check("w_icode", {60'h0, rf.w_icode}, {60'h0, mi});
         check("w_valE", rf.w_valE, mve);
         check("w_valM", rf.w_valM, mvm);
         check("w_dstE", {60'h0, rf.w_dstE}, {60'h0, mde});
         check("w_dstM", {60'h0, rf.w_dstM}, {60'h0, mdm});
         check("halted", {63'h0, rf.halted}, {63'h0, mhalt});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_m(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
      rf.m_stat = st; rf.m_icode = 4'h6; rf.m_dstE = de; rf.m_valE = ve;
      rf.m_dstM = dm; rf.m_valM = vm;
   endtask

   task automatic drive_nop();
      drive_m(3'd1, 4'hF, 64'h0, 4'hF, 64'h0);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      check("rst_w_stat", {61'h0, rf.w_stat}, 64'd1);
      check("rst_halted", {63'h0, rf.halted}, 64'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      int halt_cycles;
      reset_n = 1'b0;
      rf.w_stall = 1'b0; rf.w_bubble = 1'b0;
      rf.srcA = 4'h0; rf.srcB = 4'hF;
      drive_nop();
      repeat (2) tick();
      reset_n = 1'b1;
      cmp_en = 1'b1;

      check("reset_w_stat", {61'h0, rf.w_stat}, 64'd1);
      check("reset_w_icode", {60'h0, rf.w_icode}, 64'd1);
      check("reset_w_dstE", {60'h0, rf.w_dstE}, 64'hF);
      check("reset_w_dstM", {60'h0, rf.w_dstM}, 64'hF);
      check("reset_valA", rf.valA, 64'h0);
      check("reset_halted", {63'h0, rf.halted}, 64'd0);

      // write then read
      drive_m(3'd1, 4'd3, 64'h2A, 4'hF, 64'h0);
      tick();
      drive_nop();
      tick();
      rf.srcA = 4'd3; #1;
      check("write_read_r3", rf.valA, 64'h2A);

      // dual write to the same register: M wins
      drive_m(3'd1, 4'd4, 64'h100, 4'd4, 64'h55);
      tick();
      drive_nop();
      tick();
      rf.srcA = 4'd4; #1;
      check("dual_write_r4", rf.valA, 64'h55);

      // stall holds W, bubble inserts nop
      drive_m(3'd1, 4'd7, 64'h11, 4'hF, 64'h0);
      tick();
      rf.w_stall = 1'b1;
      drive_m(3'd1, 4'd5, 64'h99, 4'hF, 64'h0);
      tick();
      check("stall_w_dstE", {60'h0, rf.w_dstE}, 64'd7);
      tick();
      rf.srcA = 4'd5; #1;
      check("stall_r5", rf.valA, 64'h0);
      rf.w_stall = 1'b0; rf.w_bubble = 1'b1;
      tick();
      check("bubble_w_dstE", {60'h0, rf.w_dstE}, 64'hF);
      check("bubble_w_icode", {60'h0, rf.w_icode}, 64'd1);
      tick();
      check("bubble_r5", rf.valA, 64'h0);
      rf.srcA = 4'd7; #1;
      check("stall_r7", rf.valA, 64'h11);
      rf.w_bubble = 1'b0;

      // bypass of pending W write
      drive_m(3'd1, 4'd6, 64'h77, 4'hF, 64'h0);
      tick();
      rf.srcB = 4'd6; #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_valB", rf.valB, 64'h77);
`else
      check("bypass_valB", rf.valB, 64'h0);
`endif
      drive_nop();
      tick();
      check("after_write_valB", rf.valB, 64'h77);

      // halt: sticky, blocks later writes
      drive_m(3'd2, 4'hF, 64'h0, 4'hF, 64'h0);
      tick();
      check("pre_halt", {63'h0, rf.halted}, 64'd0);
      drive_m(3'd1, 4'd2, 64'hBEEF, 4'hF, 64'h0);
      tick();
      check("halted_set", {63'h0, rf.halted}, 64'd1);
      repeat (3) tick();
      rf.srcA = 4'd2; #1;
      check("halt_r2", rf.valA, 64'h0);
      check("halt_sticky", {63'h0, rf.halted}, 64'd1);

      // asynchronous reset between clock edges
      pulse_reset();
      for (int i = 0; i < 15; i++) begin
         rf.srcA = i[3:0]; #0.1;
         check("async_rst_reg", rf.valA, 64'h0);
      end
      rf.srcA = 4'hF; #0.1;
      check("async_rst_srcF", rf.valA, 64'h0);

      // randomized run
      halt_cycles = 0;
      for (int c = 0; c < 4000; c++) begin
         tick();
         rf.m_stat   = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
         rf.m_icode  = 4'($urandom_range(0, 15));
         rf.m_dstE   = 4'($urandom_range(0, 15));
         rf.m_dstM   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         rf.m_valE   = {$urandom, $urandom};
         rf.m_valM   = {$urandom, $urandom};
         rf.w_stall  = ($urandom_range(0, 7) == 0);
         rf.w_bubble = ($urandom_range(0, 7) == 0);
         rf.srcA     = 4'($urandom_range(0, 15));
         rf.srcB     = 4'($urandom_range(0, 15));
         if (mhalt) halt_cycles++;
         if (halt_cycles > 15) begin
            halt_cycles = 0;
            pulse_reset();
         end
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
